// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer for the bus CPU: fetch/decode/execute FSM driving every datapath enable.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step input and stop in IDLE after each instruction.
module control_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  output logic [NREG-1:0]   rin,
  output logic [NREG-1:0]   rout,
  output logic              gin,
  output logic              gout,
  output logic              a_in,
  output logic              addsub,
  output logic              xorctrl,
  output logic              pcin,
  output logic              pcout,
  output logic              pc_enable,
  output logic              ctrl_out,
  output logic              ram_addr_sel,
  output logic              ram_out_ctrl,
  output logic              instr_enable,
  output logic              done,
  output logic              halted,
  output logic              illegal
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EX0, S_EX1, S_EX2, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LDPC   = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_SUB    = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'hF;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [SEL_W-1:0]   rx_q, rx_d;
  logic [SEL_W-1:0]   ry_q, ry_d;

  logic isAlu, usesRx, usesRy, knownOp, rxOk, ryOk, badInstr, goOn;
  logic rxIn, rxOut, ryOut;
  logic unused_instr;

  assign unused_instr = ^instr;

  function automatic logic [NREG-1:0] oneHot(input logic [SEL_W-1:0] idx);
    oneHot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (32'(idx) == i) oneHot[i] = 1'b1;
    end
  endfunction

  // Classification uses only latched fields so outputs never depend on instr.
  assign isAlu    = (op_q == OP_SUB) || (op_q == OP_ADD) || (op_q == OP_XOR);
  assign usesRx   = isAlu || (op_q == OP_LOAD) || (op_q == OP_MOVE) ||
                    (op_q == OP_LDPC) || (op_q == OP_BRANCH);
  assign usesRy   = isAlu || (op_q == OP_MOVE);
  assign knownOp  = (op_q <= OP_XOR) || (op_q == OP_HALT);
  assign rxOk     = 32'(rx_q) < NREG;
  assign ryOk     = 32'(ry_q) < NREG;
  assign badInstr = !knownOp || (usesRx && !rxOk) || (usesRy && !ryOk);

`ifdef SEQ_SINGLE_STEP_EN
  assign goOn = 1'b0;
`else
  assign goOn = run;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    unique case (state_q)
      S_IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (run && step) state_d = S_FETCH;
`else
        if (run) state_d = S_FETCH;
`endif
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instr[DATA_W-1 -: 4];
        rx_d    = instr[DATA_W-5 -: SEL_W];
        ry_d    = instr[DATA_W-5-SEL_W -: SEL_W];
        state_d = S_EX0;
      end
      S_EX0: begin
        if (badInstr)             state_d = goOn ? S_FETCH : S_IDLE;
        else if (isAlu)           state_d = S_EX1;
        else if (op_q == OP_HALT) state_d = S_HALT;
        else                      state_d = goOn ? S_FETCH : S_IDLE;
      end
      S_EX1:  state_d = S_EX2;
      S_EX2:  state_d = goOn ? S_FETCH : S_IDLE;
      S_HALT: if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rxIn         = 1'b0;
    rxOut        = 1'b0;
    ryOut        = 1'b0;
    gin          = 1'b0;
    gout         = 1'b0;
    a_in         = 1'b0;
    addsub       = 1'b0;
    xorctrl      = 1'b0;
    pcin         = 1'b0;
    pcout        = 1'b0;
    pc_enable    = 1'b0;
    ctrl_out     = 1'b0;
    ram_addr_sel = 1'b0;
    ram_out_ctrl = 1'b0;
    instr_enable = 1'b0;
    done         = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ram_out_ctrl = 1'b1;
        instr_enable = 1'b1;
      end
      S_EX0: begin
        if (badInstr) begin
          illegal   = 1'b1;
          pc_enable = 1'b1;
          done      = 1'b1;
        end else if (isAlu) begin
          rxOut = 1'b1;
          a_in  = 1'b1;
        end else if (op_q == OP_HALT) begin
          done = 1'b1;
        end else begin
          pc_enable = 1'b1;
          done      = 1'b1;
          unique case (op_q)
            OP_LOAD:   begin ctrl_out = 1'b1; rxIn = 1'b1; end
            OP_MOVE:   begin ryOut = 1'b1; rxIn = 1'b1; end
            OP_LDPC:   begin pcout = 1'b1; rxIn = 1'b1; end
            OP_BRANCH: begin rxOut = 1'b1; pcin = 1'b1; end
            default:   ;
          endcase
        end
      end
      S_EX1: begin
        ryOut   = 1'b1;
        gin     = 1'b1;
        addsub  = (op_q == OP_SUB);
        xorctrl = (op_q == OP_XOR);
      end
      S_EX2: begin
        gout      = 1'b1;
        rxIn      = 1'b1;
        pc_enable = 1'b1;
        done      = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign rin  = rxIn ? oneHot(rx_q) : '0;
  assign rout = (rxOut ? oneHot(rx_q) : '0) | (ryOut ? oneHot(ry_q) : '0);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction expected cycle vectors are queued at issue
// and compared by a monitor anchored on each FETCH cycle.
module tb_control_sequencer;

  localparam int OW = 31;
`ifdef SEQ_SINGLE_STEP_EN
  localparam int CHAIN_GAP = 2;
`else
  localparam int CHAIN_GAP = 1;
`endif

  localparam logic [14:0] F_GIN  = 15'h4000, F_GOUT = 15'h2000, F_AIN  = 15'h1000;
  localparam logic [14:0] F_SUB  = 15'h0800, F_XOR  = 15'h0400, F_PCIN = 15'h0200;
  localparam logic [14:0] F_PCO  = 15'h0100, F_PCE  = 15'h0080, F_CTRL = 15'h0040;
  localparam logic [14:0] F_ROC  = 15'h0010, F_IEN  = 15'h0008;
  localparam logic [14:0] F_DONE = 15'h0004, F_HALT = 15'h0002, F_ILL  = 15'h0001;

  typedef struct {
    int               n;
    bit               chain;
    logic [15:0]      word;
    logic [4:0][OW-1:0] v;
  } rec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [15:0] instr;
  logic [7:0]  rin, rout;
  logic gin, gout, a_in, addsub, xorctrl, pcin, pcout, pc_enable, ctrl_out;
  logic ram_addr_sel, ram_out_ctrl, instr_enable, done, halted, illegal;
  logic [OW-1:0] outVec;

  logic [15:0] progQ[$];
  rec_t        expQ[$];
  bit          monBusy = 1'b0;
  int          cyc = 0;
  int          lastDone = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_sequencer #(.DATA_W(16), .NREG(8), .SEL_W(4)) dut (
    .clk(clk), .resetn(resetn), .run(run), .instr(instr),
    .rin(rin), .rout(rout), .gin(gin), .gout(gout), .a_in(a_in),
    .addsub(addsub), .xorctrl(xorctrl), .pcin(pcin), .pcout(pcout),
    .pc_enable(pc_enable), .ctrl_out(ctrl_out), .ram_addr_sel(ram_addr_sel),
    .ram_out_ctrl(ram_out_ctrl), .instr_enable(instr_enable), .done(done),
    .halted(halted), .illegal(illegal)
`ifdef SEQ_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  assign outVec = {rin, rout, gin, gout, a_in, addsub, xorctrl, pcin, pcout, pc_enable,
                   ctrl_out, ram_addr_sel, ram_out_ctrl, instr_enable, done, halted, illegal};

  function automatic logic [OW-1:0] ov(input logic [7:0] ri, input logic [7:0] ro,
                                       input logic [14:0] f);
    return {ri, ro, f};
  endfunction

  task automatic checkOutput(input string name, input logic [OW-1:0] act,
                             input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got rin=%h rout=%h flags=%h, want rin=%h rout=%h flags=%h",
               name, act[30:23], act[22:15], act[14:0], exp[30:23], exp[22:15], exp[14:0]);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Queue one instruction word and its hand-computed per-cycle outputs (FETCH, DECODE, EX...).
  task automatic applyStimulus(input logic [15:0] word, input bit chain, input int n,
                               input logic [OW-1:0] e0, input logic [OW-1:0] e1,
                               input logic [OW-1:0] e2);
    rec_t r;
    r.n     = n;
    r.chain = chain;
    r.word  = word;
    r.v[0]  = ov(8'h00, 8'h00, F_ROC | F_IEN);
    r.v[1]  = '0;
    r.v[2]  = e0;
    r.v[3]  = e1;
    r.v[4]  = e2;
    progQ.push_back(word);
    expQ.push_back(r);
  endtask

  task automatic waitProgTaken();
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk);
      if (progQ.size() == 0) break;
    end
    if (i == 300) checkInt("prog_timeout", progQ.size(), 0);
  endtask

  task automatic waitDrain();
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk);
      if (expQ.size() == 0 && !monBusy) break;
    end
    if (i == 300) checkInt("drain_timeout", expQ.size(), 0);
  endtask

  task automatic runBatch();
    @(negedge clk);
    run = 1'b1;
    waitProgTaken();
    #1 run = 1'b0;
    waitDrain();
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle_after_batch", outVec, '0);
    end
  endtask

  // Instruction-register model: the word is presented during FETCH and held through DECODE.
  initial begin
    instr = '0;
    forever begin
      @(negedge clk);
      if (resetn && instr_enable && progQ.size() > 0) instr = progQ.pop_front();
    end
  end

  // Monitor: each FETCH opens one transaction whose cycles are compared against the queue.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (resetn && instr_enable) begin
        if (expQ.size() == 0) begin
          checkInt("unexpected_fetch", 1, 0);
        end else begin
          r = expQ.pop_front();
          monBusy = 1'b1;
          if (r.chain) checkInt($sformatf("gap_%h", r.word), cyc - lastDone, CHAIN_GAP);
          for (int k = 0; k < r.n; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("op_%h_c%0d", r.word, k), outVec, r.v[k]);
          end
          lastDone = cyc;
          monBusy = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_state", outVec, '0);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", outVec, '0);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif

    // LOAD, ADD, SUB, XOR back to back
    applyStimulus(16'h1300, 0, 3, ov(8'h08, 8'h00, F_CTRL | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h6120, 1, 5, ov(8'h00, 8'h02, F_AIN),
                  ov(8'h00, 8'h04, F_GIN), ov(8'h02, 8'h00, F_GOUT | F_PCE | F_DONE));
    applyStimulus(16'h5450, 1, 5, ov(8'h00, 8'h10, F_AIN),
                  ov(8'h00, 8'h20, F_GIN | F_SUB), ov(8'h10, 8'h00, F_GOUT | F_PCE | F_DONE));
    applyStimulus(16'h7450, 1, 5, ov(8'h00, 8'h10, F_AIN),
                  ov(8'h00, 8'h20, F_GIN | F_XOR), ov(8'h10, 8'h00, F_GOUT | F_PCE | F_DONE));
    runBatch();

    // Single-step ops, NOP and illegal encodings including out-of-range register indices
    applyStimulus(16'h2710, 0, 3, ov(8'h80, 8'h02, F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h3200, 1, 3, ov(8'h04, 8'h00, F_PCO | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h4500, 1, 3, ov(8'h00, 8'h20, F_PCIN | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h0ABC, 1, 3, ov(8'h00, 8'h00, F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h9000, 1, 3, ov(8'h00, 8'h00, F_ILL | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h2910, 1, 3, ov(8'h00, 8'h00, F_ILL | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h6190, 1, 3, ov(8'h00, 8'h00, F_ILL | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'hC123, 1, 3, ov(8'h00, 8'h00, F_ILL | F_PCE | F_DONE), '0, '0);
    runBatch();

    // HALT holds while run stays high, leaves on run=0
    applyStimulus(16'hF000, 0, 3, ov(8'h00, 8'h00, F_DONE), '0, '0);
    @(negedge clk);
    run = 1'b1;
    waitProgTaken();
    waitDrain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("halted_%0d", i), outVec, ov(8'h00, 8'h00, F_HALT));
    end
    run = 1'b0;
    @(negedge clk);
    checkOutput("halt_exit", outVec, '0);

    // Reset during EX1 of ADD aborts without done
    applyStimulus(16'h6120, 0, 3, ov(8'h00, 8'h02, F_AIN), '0, '0);
    @(negedge clk);
    run = 1'b1;
    waitProgTaken();
    #1 run = 1'b0;
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(negedge clk);
        if (gin) break;
      end
      checkInt("reach_ex1", i < 50 ? 1 : 0, 1);
    end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_%0d", i), outVec, '0);
    end
    resetn = 1'b1;
    waitDrain();

`ifdef SEQ_SINGLE_STEP_EN
    // Two step pulses run exactly two instructions, then the FSM idles
    step = 1'b0;
    applyStimulus(16'h1300, 0, 3, ov(8'h08, 8'h00, F_CTRL | F_PCE | F_DONE), '0, '0);
    applyStimulus(16'h0000, 0, 3, ov(8'h00, 8'h00, F_PCE | F_DONE), '0, '0);
    @(negedge clk);
    run = 1'b1;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      waitDrain();
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput($sformatf("step_idle_%0d_%0d", p, i), outVec, '0);
      end
    end
    checkInt("step_prog_left", progQ.size(), 0);
    run = 1'b0;
`endif

    repeat (2) @(negedge clk);
    checkInt("leftover_expected", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor to the per-state control decoder of the 16-bit bus CPU.
- Owns the instruction-cycle FSM: fetch, decode, execute steps. Latches instruction fields and drives every bus/ALU/PC/RAM enable.
- Register file size, data width and register-select field width are parametrised. Adds run/done/halt handshaking and illegal-instruction reporting.
- Sits between the instruction register/RAM and the datapath (register file, A/G registers, PC, bus mux).

Parameters:
- DATA_W, 16, instruction/bus width; must be ≥ 12.
- NREG, 8, number of general registers; width of rin/rout; 2..16.
- SEL_W, 4, width of the rx/ry select fields; 2^SEL_W ≥ NREG.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- run  in  1  level; high = execute instructions
- instr  in  DATA_W  instruction register contents; opcode [DATA_W-1:DATA_W-4], rx [DATA_W-5 -: SEL_W], ry [DATA_W-5-SEL_W -: SEL_W]
- rin  out  NREG  one-hot register load enables
- rout  out  NREG  one-hot register bus drive enables
- gin, gout, a_in, addsub, xorctrl  out  1 each  ALU control
- pcin, pcout, pc_enable  out  1 each  PC load, PC drive, PC increment
- ctrl_out  out  1  immediate field onto bus
- ram_addr_sel, ram_out_ctrl, instr_enable  out  1 each  fetch path control
- done  out  1  one-cycle pulse on the last step of each instruction
- halted  out  1  level; high in HALT state
- illegal  out  1  one-cycle pulse on an undefined opcode or a register index ≥ NREG
- step  in  1  only when SEQ_SINGLE_STEP_EN is defined

Behaviour:
- All flops reset synchronously when resetn=0 at a rising clk: state=IDLE, latched fields=0.
  - Every output is 0 in IDLE, so all outputs are 0 after reset.
  - Reset mid-instruction aborts it: no done pulse, and outputs are 0 from the next cycle.
- Outputs decode combinationally from the state register and latched fields only. No output path from instr, run or step.
- Opcodes:
  - 0x0 NOP
  - 0x1 LOAD (ctrl_out, rx_in)
  - 0x2 MOVE (ry_out, rx_in)
  - 0x3 LDPC (pcout, rx_in)
  - 0x4 BRANCH (rx_out, pcin)
  - 0x5 SUB
  - 0x6 ADD
  - 0x7 XOR
  - 0xF HALT
  - all others illegal
- States and transitions:
  - IDLE: all outputs 0. IDLE→FETCH when run=1.
  - FETCH: ram_out_ctrl=1, instr_enable=1. The external IR loads at the end of this cycle. →DECODE.
  - DECODE: all outputs 0. Latch opcode/rx/ry from instr. →EX0.
  - EX0:
    - LOAD/MOVE/LDPC/BRANCH: single-step signals above, plus pc_enable=1 and done=1.
    - NOP: pc_enable=1, done=1.
    - ALU ops: rx_out=1, a_in=1, →EX1.
    - Illegal: illegal=1, pc_enable=1, done=1.
    - HALT: done=1, →HALT; pc_enable=0, so PC stays on the HALT word.
  - EX1: ry_out=1, gin=1; addsub=1 for SUB, xorctrl=1 for XOR. →EX2.
  - EX2: gout=1, rx_in=1, pc_enable=1, done=1.
  - After any done: →FETCH if run=1, else →IDLE.
  - HALT: halted=1, other outputs 0. HALT→IDLE only when run=0.
- Latency from FETCH entry:
  - LOAD/MOVE/LDPC/BRANCH/NOP/illegal: 3 cycles.
  - ALU ops: 5 cycles.
  - Back-to-back instructions have no idle cycle while run stays high.
- run deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- Register select:
  - rx_in/rx_out/ry_out expand to one-hot over NREG. rin = rx_in vector; rout = rx_out | ry_out vectors.
  - A latched index ≥ NREG produces an all-zero vector.
  - An in-range-opcode instruction that uses an out-of-range index is treated as illegal: EX0 illegal path, no datapath enables.
  - Fields are ignored for opcodes that do not use them (e.g. ry for LOAD).
- ram_addr_sel is 0 in all states; it is reserved for a later data-memory cycle.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - The step input exists.
  - After done, the FSM goes to IDLE regardless of run.
  - IDLE→FETCH requires run=1 and step=1 in the same cycle.
  - One step pulse executes exactly one instruction. Holding step high executes continuously.
- Undefined: no step port; behaviour is as above.

Test Plan:
- Reset then run=1, instr=0x1300 (LOAD r3) → FETCH(ram_out_ctrl=1, instr_enable=1), DECODE(all 0), EX0 rin=0x08, ctrl_out=1, pc_enable=1, done=1. Then FETCH again.
- instr=0x6120 (ADD r1,r2) → EX0 rout=0x02, a_in=1; EX1 rout=0x04, gin=1, addsub=0; EX2 gout=1, rin=0x02, done=1. 5 cycles total.
- instr=0x5450 then 0x7450 → EX1 addsub=1 for SUB; EX1 xorctrl=1, addsub=0 for XOR. Back-to-back with no gap.
- instr=0x9000 → illegal=1 for 1 cycle with pc_enable=1, rin=rout=0. With NREG=4, instr=0x2510 → illegal=1, rin=0.
- instr=0xF000 → done, then halted=1 and all enables 0 for 10 cycles with run=1. run=0 → IDLE, halted=0.
- resetn=0 during EX1 of ADD → next cycle all outputs 0, no done. With SEQ_SINGLE_STEP_EN defined: two step pulses execute exactly two instructions, then the FSM idles.
